// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Optional MDU_FAST_MUL_EN: single-cycle multiplies; divides stay iterative.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             we_hi,
    input  logic             we_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               launch;
    logic               fast_start;
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign launch    = (state_q == StIdle) && start;
    assign signed_op = ~op[0];
    assign mag_a     = (signed_op && i_a[WIDTH-1]) ? -i_a : i_a;
    assign mag_b     = (signed_op && i_b[WIDTH-1]) ? -i_b : i_b;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_start = launch & ~op[1];
    assign fast_prod  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
    assign fast_start = 1'b0;
`endif

    assign mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q, work_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign prod      = {acc_q, work_q};
    assign prod_fix  = neg_q ? -prod : prod;
    assign quot_fix  = neg_q ? -work_q : work_q;
    assign rem_fix   = rem_neg_q ? -acc_q : acc_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = fast_start ? StFin : StRun;
            StRun:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath next-state
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        if (launch) begin
            cnt_d     = '0;
            acc_d     = '0;
            work_d    = mag_a;
            opnd_d    = mag_b;
            div_d     = op[1];
            neg_d     = signed_op & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            rem_neg_d = signed_op & i_a[WIDTH-1];
            div0_d    = (i_b == '0);
`ifdef MDU_FAST_MUL_EN
            if (!op[1]) {acc_d, work_d} = fast_prod;
`endif
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                // Restoring step: keep the difference only when it did not borrow
                if (!div_diff[WIDTH]) begin
                    acc_d  = div_diff[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = div_shift[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d  = mul_sum[WIDTH:1];
                work_d = {mul_sum[0], work_q[WIDTH-1:1]};
            end
        end
    end

    // Result registers
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (state_q == StFin) begin
            done_d = 1'b1;
            if (div_q) begin
                hi_d = rem_fix;
                lo_d = div0_q ? '1 : quot_fix;
            end else begin
                {hi_d, lo_d} = prod_fix;
            end
        end else if (state_q == StIdle && !start) begin
            if (we_hi) hi_d = i_a;
            if (we_lo) lo_d = i_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
